// File: rtl/usb_gpx_event_ctrl.sv
// usb_gpx_event_ctrl
// Avalon-MM slave that conditions the MAX3421E GPX and INT pins for the Nios II USB host driver.
// Each pin passes through a synchronizer, a glitch filter and an edge detector. Edges selected
// by MODE latch into a write-1-to-clear CAPTURE register, which drives one maskable level irq.
// GPX events also bump a saturating 16-bit counter, so the driver can detect missed services.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0 DATA, 1 MODE, 2 MASK, 3 CAPTURE, 4 COUNT)
//   chipselect  slave select
//   read        read strobe (readdata valid one cycle later)
//   write       write strobe
//   writedata   write data
//   readdata    registered read data, held until the next read
//   gpx_in      MAX3421E GPX pin, asynchronous
//   int_in      MAX3421E INT pin, asynchronous
//   irq         level interrupt, registered
module usb_gpx_event_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        gpx_in,
  input  logic        int_in,
  output logic        irq
);

  localparam int unsigned CntW = (GLITCH_CYCLES < 2) ? 1 : $clog2(GLITCH_CYCLES + 1);

  // Pin index 0 is GPX, index 1 is INT throughout.
  logic [SYNC_STAGES-1:0] gpx_sync_q;
  logic [SYNC_STAGES-1:0] int_sync_q;
  logic [1:0]             synced;

  logic [CntW-1:0] flt_cnt_q [2];
  logic [CntW-1:0] flt_cnt_d [2];
  logic [1:0]      flt_q, flt_d;
  logic [1:0]      dly_q;

  logic [1:0]  rise, fall, evt;
  logic [3:0]  mode_q, mode_d;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  capture_q, capture_d;
  logic [15:0] count_q, count_d;
  logic [15:0] count_base;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] rd_mux;

  logic       wr_en, rd_en;
  logic [1:0] w1c;

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  // Synchronizers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpx_sync_q <= '0;
      int_sync_q <= '0;
    end else begin
      gpx_sync_q <= {gpx_sync_q[SYNC_STAGES-2:0], gpx_in};
      int_sync_q <= {int_sync_q[SYNC_STAGES-2:0], int_in};
    end
  end

  assign synced = {int_sync_q[SYNC_STAGES-1], gpx_sync_q[SYNC_STAGES-1]};

  // Glitch filter: filtered value follows synced only after GLITCH_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle restarts the count.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < 2; i++) begin
      flt_cnt_d[i] = '0;
      if (synced[i] != flt_q[i]) begin
        if (32'(flt_cnt_q[i]) + 32'd1 >= GLITCH_CYCLES) begin
          flt_d[i] = synced[i];
        end else begin
          flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_q <= '0;
      dly_q <= '0;
      for (int i = 0; i < 2; i++) begin
        flt_cnt_q[i] <= '0;
      end
    end else begin
      flt_q <= flt_d;
      dly_q <= flt_q;
      for (int i = 0; i < 2; i++) begin
        flt_cnt_q[i] <= flt_cnt_d[i];
      end
    end
  end

  // Edge detection against the current MODE; MODE itself never creates an edge.
  assign rise = flt_q & ~dly_q;
  assign fall = ~flt_q & dly_q;
  assign evt[0] = (rise[0] & mode_q[0]) | (fall[0] & mode_q[1]);
  assign evt[1] = (rise[1] & mode_q[2]) | (fall[1] & mode_q[3]);

  // Register next-state
  always_comb begin
    mode_d = mode_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en && address == 3'd1) mode_d = writedata[3:0];
    if (wr_en && address == 3'd2) mask_d = writedata[1:0];
    if (wr_en && address == 3'd3) w1c = writedata[1:0];

    // New events are ORed in after the clear so a coincident set wins.
    capture_d = (capture_q & ~w1c) | evt;

    // A clear write coincident with an event leaves the count at 1.
    count_base = (wr_en && address == 3'd4) ? 16'd0 : count_q;
    count_d    = count_base;
    if (evt[0] && count_base != 16'hFFFF) count_d = count_base + 16'd1;

    // irq is computed from next-state so it changes on the same edge as CAPTURE/MASK.
    irq_d = |(capture_d & mask_d);
  end

  // Read mux
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[1:0]  = flt_q;
      3'd1:    rd_mux[3:0]  = mode_q;
      3'd2:    rd_mux[1:0]  = mask_q;
      3'd3:    rd_mux[1:0]  = capture_q;
      3'd4:    rd_mux[15:0] = count_q;
      default: rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= '0;
      mask_q     <= '0;
      capture_q  <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Testbench for usb_gpx_event_ctrl.
// Instance dut_a uses default parameters for latency, filter and W1C behaviour. Instance dut_b
// uses GLITCH_CYCLES=1 so the GPX filter can pass an edge every cycle, letting COUNT saturate
// within a short run. Expected values are queued when a read or probe is issued; a monitor
// on the falling clock edge pops and compares them.
module tb_usb_gpx_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic        cs_a, cs_b;
  logic        gpx_a, int_a, gpx_b;
  logic        int_b = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  usb_gpx_event_ctrl dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs_a),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (rdata_a),
    .gpx_in     (gpx_a),
    .int_in     (int_a),
    .irq        (irq_a)
  );

  usb_gpx_event_ctrl #(
    .SYNC_STAGES   (2),
    .GLITCH_CYCLES (1)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs_b),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (rdata_b),
    .gpx_in     (gpx_b),
    .int_in     (int_b),
    .irq        (irq_b)
  );

  // Scoreboard queues
  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic        irq_exp_q [$];
  string       irq_name_q [$];

  int checks = 0;
  int errors = 0;

  logic rd_pend_a = 1'b0;
  logic rd_pend_b = 1'b0;
  logic rd_probe  = 1'b0;
  logic irq_probe = 1'b0;

  always @(posedge clk) begin
    rd_pend_a <= cs_a & read;
    rd_pend_b <= cs_b & read;
  end

  // Monitor
  always @(negedge clk) begin
    logic [31:0] exp_d, act_d;
    logic        exp_i;
    string       nm;
    if (rd_pend_a || rd_pend_b || rd_probe) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_queue_empty: readdata response with no expected value");
      end else begin
        exp_d = rd_exp_q.pop_front();
        nm    = rd_name_q.pop_front();
        act_d = rd_pend_b ? rdata_b : rdata_a;
        if (act_d !== exp_d) begin
          errors++;
          $display("FAIL %s: readdata got 0x%08h expected 0x%08h", nm, act_d, exp_d);
        end
      end
    end
    if (irq_probe) begin
      checks++;
      if (irq_exp_q.size() == 0) begin
        errors++;
        $display("FAIL irq_queue_empty: irq probe with no expected value");
      end else begin
        exp_i = irq_exp_q.pop_front();
        nm    = irq_name_q.pop_front();
        if (irq_a !== exp_i) begin
          errors++;
          $display("FAIL %s: irq got %b expected %b", nm, irq_a, exp_i);
        end
      end
    end
  end

  // Every step leaves the bench 1 time unit after a rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input bit b, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    cs_a      = ~b;
    cs_b      = b;
    step();
    write = 1'b0;
    cs_a  = 1'b0;
    cs_b  = 1'b0;
  endtask

  task automatic bus_rd(input bit b, input logic [2:0] a, input logic [31:0] exp,
                        input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    address = a;
    read    = 1'b1;
    cs_a    = ~b;
    cs_b    = b;
    step();
    read = 1'b0;
    cs_a = 1'b0;
    cs_b = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    irq_exp_q.push_back(exp);
    irq_name_q.push_back(nm);
    irq_probe = 1'b1;
    step();
    irq_probe = 1'b0;
  endtask

  initial begin
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    gpx_a     = 1'b0;
    int_a     = 1'b0;
    gpx_b     = 1'b0;
    reset_n   = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(2);

    // Reset state: every address reads 0, irq low
    for (int a = 0; a < 8; a++) bus_rd(1'b0, 3'(a), 32'h0, "reset_read");
    chk_irq(1'b0, "reset_irq");

    // GPX rising edge: irq exactly after E6
    bus_wr(1'b0, 3'd1, 32'h1);
    bus_wr(1'b0, 3'd2, 32'h1);
    gpx_a = 1'b1;
    step(6);
    chk_irq(1'b0, "gpx_irq_before_e6");
    chk_irq(1'b1, "gpx_irq_after_e6");
    bus_rd(1'b0, 3'd3, 32'h1, "cap_gpx");
    bus_rd(1'b0, 3'd4, 32'h1, "count_one");
    bus_rd(1'b0, 3'd0, 32'h1, "data_gpx_high");
    bus_wr(1'b0, 3'd3, 32'h1);
    chk_irq(1'b0, "irq_after_w1c");
    bus_rd(1'b0, 3'd3, 32'h0, "cap_cleared");

    // INT both edges, MASK off: short pulse filtered out, 4-cycle pulse gives rise and fall
    bus_wr(1'b0, 3'd2, 32'h0);
    bus_wr(1'b0, 3'd1, 32'hC);
    int_a = 1'b1;
    step(3);
    int_a = 1'b0;
    step(12);
    bus_rd(1'b0, 3'd3, 32'h0, "int_short_pulse");
    int_a = 1'b1;
    step(4);
    int_a = 1'b0;
    step(3);
    bus_rd(1'b0, 3'd3, 32'h2, "int_rise_event");
    bus_wr(1'b0, 3'd3, 32'h2);
    bus_rd(1'b0, 3'd3, 32'h0, "int_cleared_between");
    step(5);
    bus_rd(1'b0, 3'd3, 32'h2, "int_fall_event");
    chk_irq(1'b0, "int_irq_masked");
    bus_rd(1'b0, 3'd4, 32'h1, "count_int_ignored");
    bus_rd(1'b0, 3'd0, 32'h1, "data_int_low");

    // W1C coincident with a GPX falling-edge set: set wins
    bus_wr(1'b0, 3'd3, 32'h3);
    bus_wr(1'b0, 3'd1, 32'h2);
    bus_wr(1'b0, 3'd2, 32'h1);
    gpx_a = 1'b0;
    step(6);
    bus_wr(1'b0, 3'd3, 32'h1);
    chk_irq(1'b1, "irq_set_wins");
    bus_rd(1'b0, 3'd3, 32'h1, "cap_set_wins");
    bus_rd(1'b0, 3'd4, 32'h2, "count_two");

    // Saturation on dut_b: one GPX event per cycle with MODE both
    bus_wr(1'b1, 3'd1, 32'h3);
    for (int i = 0; i < 65545; i++) begin
      gpx_b = ~gpx_b;
      step();
    end
    step(10);
    bus_rd(1'b1, 3'd4, 32'h0000FFFF, "count_saturated");
    gpx_b = ~gpx_b;
    step(3);
    bus_wr(1'b1, 3'd4, 32'h0);
    bus_rd(1'b1, 3'd4, 32'h1, "count_clear_with_event");

    // Asynchronous reset mid-filter while irq is high
    bus_rd(1'b0, 3'd1, 32'h2, "mode_readback");
    chk_irq(1'b1, "irq_before_reset");
    gpx_a = 1'b1;
    step(3);
    reset_n = 1'b0;
    rd_exp_q.push_back(32'h0);
    rd_name_q.push_back("rdata_async_reset");
    irq_exp_q.push_back(1'b0);
    irq_name_q.push_back("irq_async_reset");
    rd_probe  = 1'b1;
    irq_probe = 1'b1;
    step();
    rd_probe  = 1'b0;
    irq_probe = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(12);
    bus_rd(1'b0, 3'd3, 32'h0, "cap_after_reset");
    bus_rd(1'b0, 3'd1, 32'h0, "mode_after_reset");
    bus_rd(1'b0, 3'd0, 32'h1, "data_after_reset");
    chk_irq(1'b0, "irq_after_reset");

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
